// File: rtl/time_preset_writer.sv
// ---------------------------------------------------------------------------
// time_preset_writer
//   User-entry controller that edits an MM:SS preset and writes it into the
//   four stopwatch digit counters through their preset/load inputs.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   run        in   stopwatch running; editing is blocked (and aborted) while high
//   mode       in   pulse: enter edit from idle / advance digit select in edit
//   inc, dec   in   pulses: increment / decrement the selected digit
//   commit     in   pulse: load the edited value into the counters
//   abort      in   pulse: discard edits, restore the last committed value
//   sec_lo, sec_hi, min_lo, min_hi  out  preset digits (working copy)
//   set        out  load strobe, high for SET_LEN cycles after a commit
//   sel        out  selected digit: 0=sec_lo 1=sec_hi 2=min_lo 3=min_hi
//   editing    out  high while in the edit state (display blink enable)
// ---------------------------------------------------------------------------
module time_preset_writer #(
  parameter int LO_MAX  = 9,
  parameter int HI_MAX  = 5,
  parameter int SET_LEN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mode,
  input  logic       inc,
  input  logic       dec,
  input  logic       commit,
  input  logic       abort,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       set,
  output logic [1:0] sel,
  output logic       editing
);

  localparam logic [3:0] LO_V  = 4'(LO_MAX);
  localparam logic [3:0] HI_V  = 4'(HI_MAX);
  localparam logic [3:0] LEN_V = 4'(SET_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] work_q [4];
  logic [3:0] work_d [4];
  logic [3:0] comm_q [4];
  logic [3:0] comm_d [4];
  logic [1:0] sel_q, sel_d;
  logic       set_q, set_d;
  logic       edit_q, edit_d;
  logic [3:0] cnt_q, cnt_d;

  // Odd select indices are the tens digits, which wrap at HI_MAX.
  function automatic logic [3:0] digit_max(input logic [1:0] idx);
    return idx[0] ? HI_V : LO_V;
  endfunction

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    comm_d  = comm_q;
    sel_d   = sel_q;
    set_d   = set_q;
    edit_d  = edit_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (mode && !run) begin
          state_d = EDIT;
          sel_d   = 2'd0;
          edit_d  = 1'b1;
        end
      end

      EDIT: begin
        // A running stopwatch cannot be edited, so run forces an abort
        // even over a simultaneous commit.
        if (run || (abort && !commit)) begin
          state_d = IDLE;
          work_d  = comm_q;
          sel_d   = 2'd0;
          edit_d  = 1'b0;
        end else if (commit) begin
          state_d = LOAD;
          comm_d  = work_q;
          set_d   = 1'b1;
          cnt_d   = LEN_V;
          edit_d  = 1'b0;
        end else if (mode) begin
          sel_d = sel_q + 2'd1;
        end else if (inc && !dec) begin
          work_d[sel_q] = (work_q[sel_q] >= digit_max(sel_q)) ? 4'd0
                                                              : work_q[sel_q] + 4'd1;
        end else if (dec && !inc) begin
          work_d[sel_q] = (work_q[sel_q] == 4'd0) ? digit_max(sel_q)
                                                  : work_q[sel_q] - 4'd1;
        end
      end

      LOAD: begin
        // cnt_q counts the strobe cycles still to be shown, including this one.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          set_d   = 1'b0;
          sel_d   = 2'd0;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        set_d   = 1'b0;
        edit_d  = 1'b0;
        sel_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      set_q   <= 1'b0;
      edit_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      set_q   <= set_d;
      edit_q  <= edit_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        work_q[gi] <= 4'd0;
        comm_q[gi] <= 4'd0;
      end else begin
        work_q[gi] <= work_d[gi];
        comm_q[gi] <= comm_d[gi];
      end
    end
  end

  assign sec_lo  = work_q[0];
  assign sec_hi  = work_q[1];
  assign min_lo  = work_q[2];
  assign min_hi  = work_q[3];
  assign set     = set_q;
  assign sel     = sel_q;
  assign editing = edit_q;

endmodule
